divui_iter: RTL
===============

# divui_iter

Iterative unsigned integer divider for the elastic dataflow arithmetic library. It sits directly downstream of zero-extension stages (a zero-extended operand feeding an unsigned division is the common pattern) and consumes their valid/ready streams. It joins two operands, computes one quotient bit per cycle with restoring division, and holds the result until the consumer accepts it. It is the area-lean alternative to a fully pipelined divider and has one operation in flight.

## Interface
- DATA_TYPE, 32, operand and result width in bits (≥ 2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- lhs  in  DATA_TYPE  dividend
- lhs_valid  in  1  dividend valid
- lhs_ready  out  1  dividend accepted this cycle when high together with lhs_valid
- rhs  in  DATA_TYPE  divisor
- rhs_valid  in  1  divisor valid
- rhs_ready  out  1  divisor accepted this cycle when high together with rhs_valid
- result  out  DATA_TYPE  quotient (floor(lhs/rhs))
- result_valid  out  1  quotient valid
- result_ready  in  1  consumer accepts quotient

Clock and reset are decided: one clock, reset synchronous and active-high.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, bit counter = 0, result = 0, result_valid = 0, lhs_ready = 0 unless rhs_valid, rhs_ready = 0 unless lhs_valid.
- Join: lhs_ready = (state==IDLE) & rhs_valid; rhs_ready = (state==IDLE) & lhs_valid. Neither operand is consumed alone.
- IDLE: on lhs_valid & rhs_valid, capture dividend into quotient shift register, divisor into divisor register, clear partial remainder (DATA_TYPE+1 bits), counter = DATA_TYPE-1, go BUSY.
- BUSY, each cycle: shift {rem, quo} left by 1; trial = rem − {0,divisor}; if trial non-negative, rem = trial, quotient LSB = 1, else LSB = 0. Counter == 0 → DONE, else decrement.
- DONE: result = quotient register, result_valid = 1, held stable until result_ready; on result_valid & result_ready → IDLE.
- Divide by zero: no special case; restoring algorithm yields all-ones quotient; same latency. Required behaviour, checked.
- Remainder discarded (not exported).
- Reset in any state returns to IDLE next edge; in-flight operation dropped, no result emitted.

## Timing
- Operands accepted in cycle t (both valids high, state IDLE).
- BUSY cycles t+1 … t+DATA_TYPE.
- result_valid first high in cycle t+DATA_TYPE+1; latency DATA_TYPE+1 cycles.
- Earliest next operand acceptance: cycle after result handshake (state back to IDLE); initiation interval DATA_TYPE+2 with result_ready held high.
- lhs_ready/rhs_ready combinational from state and opposite valid; result_valid and result registered (no combinational path from inputs to outputs except ready join).
- Operand inputs ignored outside IDLE; changes there have no effect.
- result_ready low in DONE: stall indefinitely, result unchanged.

## Structure
- Shared arithmetic package: state enum (IDLE, BUSY, DONE) and counter width function clog2(DATA_TYPE).
- One sub-module natural: divui_iter_step, combinational one-bit restoring step (inputs rem, quo, divisor; outputs next rem, next quo), reusable by a future unrolled or pipelined divider.
- Top module: FSM, counter, registers, join logic.

## Test plan
- DATA_TYPE=8, lhs=100, rhs=7, result_ready=1 → result=14, result_valid high exactly 9 cycles after acceptance, single cycle.
- DATA_TYPE=8, lhs=255, rhs=0 → result=255 (all ones), same 9-cycle latency.
- DATA_TYPE=32, lhs=0xFFFFFFFF, rhs=1 → 0xFFFFFFFF; lhs=5, rhs=9 → 0; lhs=0x80000000, rhs=0x10 → 0x08000000.
- Join: lhs_valid high, rhs_valid low for 5 cycles → lhs_ready and rhs_ready both low, nothing captured; rhs_valid rises with rhs=3, lhs=12 → both readies high that cycle, result 4.
- Backpressure: result_ready low 10 cycles in DONE → result_valid stays 1, result stable, lhs_ready/rhs_ready 0; new valid operands accepted only cycle after result_ready rises.
- Reset mid-BUSY (cycle t+3) → next cycle IDLE, result_valid 0, no result emitted; subsequent 20/6 → 3.
- Random scoreboard: 10k random DATA_TYPE=16 pairs (incl. rhs=0) with random valid/ready gaps → results in order match floor division (all ones for rhs=0).

Source files
------------

// File: rtl/divui_iter_pkg.sv
// Shared definitions for the iterative unsigned divider family:
// controller state encoding and counter sizing.
package divui_iter_pkg;

    // Controller states: waiting for operands, iterating, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count DATA_TYPE-1 down to 0 (never less than one bit).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage : divui_iter_pkg

// File: rtl/divui_iter_step.sv
// One restoring-division step: shift {rem, quo} left by one, try to
// subtract the divisor, keep the difference and set the new quotient bit
// when it did not go negative. Purely combinational so it can be chained
// for an unrolled or pipelined divider.
module divui_iter_step #(
    parameter int DATA_TYPE = 32
) (
    input  logic [DATA_TYPE:0]   i_rem,
    input  logic [DATA_TYPE-1:0] i_quo,
    input  logic [DATA_TYPE-1:0] i_divisor,
    output logic [DATA_TYPE:0]   o_rem,
    output logic [DATA_TYPE-1:0] o_quo
);

    // Partial remainder after shifting in the next dividend bit. One extra
    // top bit keeps the subtraction sign-exact; it is always zero because
    // the incoming remainder is smaller than the divisor.
    logic [DATA_TYPE+1:0] w_shift;
    logic [DATA_TYPE+1:0] w_trial;
    logic                 w_negative;

    assign w_shift    = {i_rem, i_quo[DATA_TYPE-1]};
    assign w_trial    = w_shift - {2'b00, i_divisor};
    assign w_negative = w_trial[DATA_TYPE+1];

    assign o_rem = w_negative ? w_shift[DATA_TYPE:0] : w_trial[DATA_TYPE:0];
    assign o_quo = {i_quo[DATA_TYPE-2:0], ~w_negative};

endmodule : divui_iter_step

// File: rtl/divui_iter.sv
// Iterative unsigned divider: joins a dividend and a divisor stream,
// produces one quotient bit per cycle with restoring division and holds
// floor(lhs/rhs) until the consumer takes it. One operation in flight.
// A zero divisor needs no special case: every trial subtraction succeeds
// and the quotient comes out all ones with the normal latency.
module divui_iter
    import divui_iter_pkg::*;
#(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    output logic [DATA_TYPE-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam int                CNT_W    = clog2(DATA_TYPE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_TYPE - 1);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [CNT_W-1:0]       r_count;
    logic [DATA_TYPE:0]     r_rem;
    logic [DATA_TYPE-1:0]   r_quo;
    logic [DATA_TYPE-1:0]   r_divisor;
    logic [DATA_TYPE-1:0]   r_result;

    logic [DATA_TYPE:0]     w_step_rem;
    logic [DATA_TYPE-1:0]   w_step_quo;
    logic                   w_idle;
    logic                   w_accept;
    logic                   w_last;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & lhs_valid & rhs_valid;
    assign w_last   = (r_count == '0);

    // Join: each side is only offered ready when the other side is valid,
    // so neither operand can be consumed on its own.
    assign lhs_ready = w_idle & rhs_valid;
    assign rhs_ready = w_idle & lhs_valid;

    // Result and its valid come straight from registers.
    assign result       = r_result;
    assign result_valid = (r_state == DONE);

    divui_iter_step #(
        .DATA_TYPE (DATA_TYPE)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // State register; reset drops any operation in flight.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment before the case guarantees every path
    // drives w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept)     w_next_state = BUSY;
            BUSY: if (w_last)       w_next_state = DONE;
            DONE: if (result_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Datapath: capture operands, iterate one quotient bit per cycle,
    // latch the finished quotient into the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_quo     <= lhs;
                        r_divisor <= rhs;
                        r_rem     <= '0;
                        r_count   <= CNT_LAST;
                    end
                end
                BUSY: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    if (w_last) begin
                        r_result <= w_step_quo;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : divui_iter
